// File: rtl/rs_issue_scheduler.sv
// Wakeup/select controller for a 16-row reservation station: oldest-first issue to two
// single-cycle ALUs and one non-pipelined multiplier, with destination-register wakeup.
module rs_issue_scheduler #(
  parameter int RS_N    = 16,
  parameter int ROB_W   = 4,
  parameter int PREG_W  = 6,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ROB_W-1:0]      rob_head,
  input  logic [RS_N-1:0]       rs_valid,
  input  logic [RS_N-1:0]       rs_ready,
  input  logic [RS_N-1:0]       rs_is_mul,
  input  logic [RS_N*ROB_W-1:0] rs_rob_idx,
  input  logic [RS_N*PREG_W-1:0] rs_pd,
  output logic [RS_N-1:0]       issue_grant,
  output logic [2:0]            fu_issue_valid,
  output logic [11:0]           fu_issue_rs,
  output logic [3*PREG_W-1:0]   fu_issue_pd,
  output logic                  mul_busy,
  output logic [2:0]            wakeup_valid,
  output logic [3*PREG_W-1:0]   wakeup_pd
);

  localparam int ROW_W = 4;
  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  logic [ROB_W-1:0]  row_age [RS_N];
  logic [RS_N-1:0]   cand_alu;
  logic [RS_N-1:0]   cand_mul;

  logic              alu0_found, alu1_found, mul_found;
  logic [ROW_W-1:0]  alu0_idx, alu1_idx, mul_idx;
  logic [ROB_W-1:0]  alu0_age, alu1_age, mul_age;
  logic              grant_alu0, grant_alu1, grant_mul;

  logic [2:0]          fu_issue_valid_q, fu_issue_valid_d;
  logic [11:0]         fu_issue_rs_q, fu_issue_rs_d;
  logic [3*PREG_W-1:0] fu_issue_pd_q, fu_issue_pd_d;
  logic [CNT_W-1:0]    mul_cnt_q, mul_cnt_d;
  logic [PREG_W-1:0]   mul_pd_q, mul_pd_d;

  // Age is the distance from the ROB head, so wrap-around ranks correctly.
  always_comb begin
    for (int r = 0; r < RS_N; r++) begin
      row_age[r] = rs_rob_idx[r*ROB_W +: ROB_W] - rob_head;
    end
    cand_alu = rs_valid & rs_ready & ~rs_is_mul;
    cand_mul = rs_valid & rs_ready & rs_is_mul;
  end

  // Strict less-than while scanning upward makes equal ages favour the lower row.
  always_comb begin
    alu0_found = 1'b0;
    alu0_idx   = '0;
    alu0_age   = '0;
    alu1_found = 1'b0;
    alu1_idx   = '0;
    alu1_age   = '0;
    mul_found  = 1'b0;
    mul_idx    = '0;
    mul_age    = '0;
    for (int r = 0; r < RS_N; r++) begin
      if (cand_alu[r] && (!alu0_found || row_age[r] < alu0_age)) begin
        alu0_found = 1'b1;
        alu0_idx   = ROW_W'(r);
        alu0_age   = row_age[r];
      end
      if (cand_mul[r] && (!mul_found || row_age[r] < mul_age)) begin
        mul_found = 1'b1;
        mul_idx   = ROW_W'(r);
        mul_age   = row_age[r];
      end
    end
    for (int r = 0; r < RS_N; r++) begin
      if (cand_alu[r] && (ROW_W'(r) != alu0_idx) &&
          (!alu1_found || row_age[r] < alu1_age)) begin
        alu1_found = 1'b1;
        alu1_idx   = ROW_W'(r);
        alu1_age   = row_age[r];
      end
    end
  end

  always_comb begin
    grant_alu0  = alu0_found && !flush && !rst;
    grant_alu1  = alu1_found && !flush && !rst;
    grant_mul   = mul_found && (mul_cnt_q <= CNT_W'(1)) && !flush && !rst;
    issue_grant = '0;
    if (grant_alu0) issue_grant[alu0_idx] = 1'b1;
    if (grant_alu1) issue_grant[alu1_idx] = 1'b1;
    if (grant_mul)  issue_grant[mul_idx]  = 1'b1;
  end

  always_comb begin
    fu_issue_valid_d = {grant_mul, grant_alu1, grant_alu0};
    fu_issue_rs_d    = {mul_idx, alu1_idx, alu0_idx};
    fu_issue_pd_d    = {rs_pd[mul_idx*PREG_W +: PREG_W],
                        rs_pd[alu1_idx*PREG_W +: PREG_W],
                        rs_pd[alu0_idx*PREG_W +: PREG_W]};
    mul_pd_d         = mul_pd_q;
    mul_cnt_d        = mul_cnt_q;
    if (flush) begin
      fu_issue_valid_d = '0;
      mul_cnt_d        = '0;
    end else if (grant_mul) begin
      // Back-to-back MUL in the wakeup cycle reloads instead of decrementing.
      mul_cnt_d = CNT_W'(MUL_LAT);
      mul_pd_d  = rs_pd[mul_idx*PREG_W +: PREG_W];
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_issue_valid_q <= '0;
      fu_issue_rs_q    <= '0;
      fu_issue_pd_q    <= '0;
      mul_cnt_q        <= '0;
      mul_pd_q         <= '0;
    end else begin
      fu_issue_valid_q <= fu_issue_valid_d;
      fu_issue_rs_q    <= fu_issue_rs_d;
      fu_issue_pd_q    <= fu_issue_pd_d;
      mul_cnt_q        <= mul_cnt_d;
      mul_pd_q         <= mul_pd_d;
    end
  end

  always_comb begin
    fu_issue_valid = fu_issue_valid_q;
    fu_issue_rs    = fu_issue_rs_q;
    fu_issue_pd    = fu_issue_pd_q;
    mul_busy       = (mul_cnt_q > CNT_W'(1));
    wakeup_pd      = {mul_pd_q, fu_issue_pd_q[2*PREG_W-1:0]};
    wakeup_valid   = {(mul_cnt_q == CNT_W'(1)), fu_issue_valid_q[1:0]};
    if (flush) wakeup_valid = '0;
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: reset, age ordering, wrap, MUL latency, flush, mixed issue.
module tb_rs_issue_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  rob_head;
  logic [15:0] rs_valid, rs_ready, rs_is_mul;
  logic [63:0] rs_rob_idx;
  logic [95:0] rs_pd;
  logic [15:0] issue_grant;
  logic [2:0]  fu_issue_valid;
  logic [11:0] fu_issue_rs;
  logic [17:0] fu_issue_pd;
  logic        mul_busy;
  logic [2:0]  wakeup_valid;
  logic [17:0] wakeup_pd;

  int tests = 0;
  int fails = 0;

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_is_mul(rs_is_mul),
    .rs_rob_idx(rs_rob_idx), .rs_pd(rs_pd), .issue_grant(issue_grant),
    .fu_issue_valid(fu_issue_valid), .fu_issue_rs(fu_issue_rs),
    .fu_issue_pd(fu_issue_pd), .mul_busy(mul_busy),
    .wakeup_valid(wakeup_valid), .wakeup_pd(wakeup_pd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input int r, input logic rdy, input logic mul,
                         input logic [3:0] rob, input logic [5:0] pd);
    rs_valid[r]           = 1'b1;
    rs_ready[r]           = rdy;
    rs_is_mul[r]          = mul;
    rs_rob_idx[r*4 +: 4]  = rob;
    rs_pd[r*6 +: 6]       = pd;
  endtask

  task automatic clr_row(input int r);
    rs_valid[r] = 1'b0;
    rs_ready[r] = 1'b0;
  endtask

  task automatic clr_all();
    rs_valid = '0; rs_ready = '0; rs_is_mul = '0; rs_rob_idx = '0; rs_pd = '0;
  endtask

  // Advance to just after the next rising edge, then let combinational paths settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rob_head = 4'd0;
    clr_all();
    #2;
    chk("rst_valid", fu_issue_valid, 3'b000);
    chk("rst_wakeup", wakeup_valid, 3'b000);
    chk("rst_busy", mul_busy, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;

    // 1: reset in the middle of a MUL
    set_row(0, 1, 1, 4'd0, 6'd10);
    #1 chk("t1_grant", issue_grant, 16'h0001);
    step();
    clr_row(0);
    #1 chk("t1_busy_n1", mul_busy, 1'b1);
    chk("t1_fuv_n1", fu_issue_valid, 3'b100);
    step();
    chk("t1_busy_n2", mul_busy, 1'b1);
    set_row(3, 1, 0, 4'd1, 6'd3);
    rst = 1'b1;
    #1;
    chk("t1_rst_grant", issue_grant, 16'h0000);
    chk("t1_rst_busy", mul_busy, 1'b0);
    chk("t1_rst_fuv", fu_issue_valid, 3'b000);
    chk("t1_rst_wake", wakeup_valid, 3'b000);
    chk("t1_rst_fupd", fu_issue_pd, 18'h0);
    step();
    clr_all();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_post_wake", wakeup_valid, 3'b000);
    end

    // 2: oldest-first
    rob_head = 4'd0;
    set_row(3, 1, 0, 4'd5, 6'd13);
    set_row(7, 1, 0, 4'd2, 6'd17);
    set_row(9, 0, 0, 4'd1, 6'd19);
    #1 chk("t2_grant", issue_grant, 16'h0088);
    step();
    clr_row(3); clr_row(7);
    #1;
    chk("t2_fuv", fu_issue_valid, 3'b011);
    chk("t2_rs0", fu_issue_rs[3:0], 4'd7);
    chk("t2_rs1", fu_issue_rs[7:4], 4'd3);
    chk("t2_wake", wakeup_valid, 3'b011);
    chk("t2_wpd0", wakeup_pd[5:0], 6'd17);
    chk("t2_wpd1", wakeup_pd[11:6], 6'd13);
    chk("t2_idle_grant", issue_grant, 16'h0000);
    step();
    chk("t2_fuv_done", fu_issue_valid, 3'b000);
    clr_all();

    // 3: ROB wrap-around
    rob_head = 4'd14;
    set_row(1, 1, 0, 4'd15, 6'd21);
    set_row(2, 1, 0, 4'd0, 6'd22);
    set_row(5, 1, 0, 4'd14, 6'd25);
    #1 chk("t3_grant", issue_grant, 16'h0022);
    step();
    clr_row(1); clr_row(5);
    #1;
    chk("t3_rs0", fu_issue_rs[3:0], 4'd5);
    chk("t3_rs1", fu_issue_rs[7:4], 4'd1);
    chk("t3_grant2", issue_grant, 16'h0004);
    step();
    clr_row(2);
    #1;
    chk("t3_fuv2", fu_issue_valid, 3'b001);
    chk("t3_rs0b", fu_issue_rs[3:0], 4'd2);
    chk("t3_pd0b", fu_issue_pd[5:0], 6'd22);
    step();
    clr_all();

    // 4: MUL latency and back-to-back
    rob_head = 4'd0;
    set_row(4, 1, 1, 4'd3, 6'd40);
    #1 chk("t4_grant_n", issue_grant, 16'h0010);
    step();
    clr_row(4);
    set_row(6, 1, 1, 4'd4, 6'd41);
    #1;
    chk("t4_busy_n1", mul_busy, 1'b1);
    chk("t4_grant_n1", issue_grant, 16'h0000);
    chk("t4_wake_n1", wakeup_valid, 3'b000);
    chk("t4_fuv_n1", fu_issue_valid, 3'b100);
    chk("t4_fupd_n1", fu_issue_pd[17:12], 6'd40);
    chk("t4_furs_n1", fu_issue_rs[11:8], 4'd4);
    step();
    chk("t4_busy_n2", mul_busy, 1'b1);
    chk("t4_grant_n2", issue_grant, 16'h0000);
    chk("t4_wake_n2", wakeup_valid, 3'b000);
    step();
    chk("t4_busy_n3", mul_busy, 1'b0);
    chk("t4_wake_n3", wakeup_valid, 3'b100);
    chk("t4_wpd_n3", wakeup_pd[17:12], 6'd40);
    chk("t4_grant_n3", issue_grant, 16'h0040);
    step();
    clr_row(6);
    #1;
    chk("t4_busy_n4", mul_busy, 1'b1);
    chk("t4_wake_n4", wakeup_valid, 3'b000);
    chk("t4_fupd_n4", fu_issue_pd[17:12], 6'd41);
    step();
    chk("t4_wake_n5", wakeup_valid, 3'b000);
    step();
    chk("t4_wake_n6", wakeup_valid, 3'b100);
    chk("t4_wpd_n6", wakeup_pd[17:12], 6'd41);
    step();
    chk("t4_wake_n7", wakeup_valid, 3'b000);

    // 5: flush kills in-flight ALU and MUL work
    set_row(1, 1, 0, 4'd1, 6'd5);
    set_row(4, 1, 1, 4'd2, 6'd40);
    #1 chk("t5_grant_n", issue_grant, 16'h0012);
    step();
    clr_all();
    set_row(8, 1, 0, 4'd3, 6'd8);
    flush = 1'b1;
    #1;
    chk("t5_grant_flush", issue_grant, 16'h0000);
    chk("t5_wake_flush", wakeup_valid, 3'b000);
    step();
    flush = 1'b0;
    clr_all();
    #1;
    chk("t5_busy_n2", mul_busy, 1'b0);
    chk("t5_fuv_n2", fu_issue_valid, 3'b000);
    chk("t5_wake_n2", wakeup_valid, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_wake_late", wakeup_valid, 3'b000);
    end

    // 6: mixed ALU + MUL issue
    rob_head = 4'd0;
    set_row(0, 1, 0, 4'd3, 6'd30);
    set_row(2, 1, 0, 4'd1, 6'd32);
    set_row(10, 1, 0, 4'd2, 6'd34);
    set_row(12, 1, 1, 4'd4, 6'd50);
    #1;
    chk("t6_grant", issue_grant, 16'h1404);
    chk("t6_count", $countones(issue_grant), 3);
    step();
    clr_row(2); clr_row(10); clr_row(12);
    #1;
    chk("t6_fuv", fu_issue_valid, 3'b111);
    chk("t6_rs", fu_issue_rs, 12'hCA2);
    chk("t6_grant2", issue_grant, 16'h0001);
    step();
    clr_all();
    #1;
    chk("t6_fuv2", fu_issue_valid, 3'b001);
    chk("t6_rs0b", fu_issue_rs[3:0], 4'd0);
    chk("t6_pd0b", fu_issue_pd[5:0], 6'd30);
    step();
    chk("t6_wake_mul", wakeup_valid, 3'b100);
    chk("t6_wpd_mul", wakeup_pd[17:12], 6'd50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
